// File: rtl/mem_write_checker_if.sv
// Monitored memory-write bus: one write strobe with its address and data.
// Latency: none, this is wiring only. Backpressure: none, since the bus is observe-only.
// Ports: master drives mem_write/data_adr/write_data; slave (the checker) only samples them.
interface mem_write_checker_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_write;
   logic [ADDR_W-1:0] data_adr;
   logic [DATA_W-1:0] write_data;

   modport master (output mem_write, output data_adr, output write_data);
   modport slave  (input  mem_write, input  data_adr, input  write_data);
endinterface

// File: rtl/mem_write_checker.sv
// Compares a monitored write stream against a table of expected (addr, data) writes.
// Latency: pass/fail is registered 1 cycle after the deciding write edge. Backpressure: none, because the bus is only observed.
// Ports: clk/reset; cfg_* loads the table and length; start arms; wr is the monitored bus;
//        busy/done/pass/fail/timeout are status; fail_* describe the failure; cycle_count counts RUN cycles.
module mem_write_checker #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                DEPTH       = 4,
   parameter logic [ADDR_W-1:0] IGNORE_ADDR = 96,
   parameter int                TIMEOUT     = 1024,
   parameter bit                STRICT      = 1'b1,
   localparam int               IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_we,
   input  logic [IW-1:0]       cfg_idx,
   input  logic [ADDR_W-1:0]   cfg_addr,
   input  logic [DATA_W-1:0]   cfg_data,
   input  logic [IW:0]         cfg_len,
   input  logic                start,
   mem_write_checker_if.slave  wr,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic                timeout,
   output logic [IW-1:0]       fail_idx,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_data,
   output logic [31:0]         cycle_count
);

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] exp_addr [DEPTH];
   logic [DATA_W-1:0] exp_data [DEPTH];
   // ptr carries one extra bit so it can step past the last entry without wrapping.
   logic [IW:0]       len, ptr;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic [IW:0]       len_clamped;
   logic              hit, ignored, at_limit;
   logic              arm, ptr_inc, fail_wr, fail_to;

   assign len_clamped = (cfg_len > (IW+1)'(DEPTH)) ? (IW+1)'(DEPTH) : cfg_len;
   assign ignored     = wr.data_adr == IGNORE_ADDR;
   assign at_limit    = cycle_count == 32'(TIMEOUT - 1);

   // Table read through a compare loop, so a ptr that has stepped past
   // DEPTH yields zeros instead of indexing out of range.
   always_comb begin
      cur_addr = '0;
      cur_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ptr == (IW+1)'(i)) begin
            cur_addr = exp_addr[i];
            cur_data = exp_data[i];
         end
      end
   end

   assign hit = (wr.data_adr == cur_addr) && (wr.write_data == cur_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      arm       = 1'b0;
      ptr_inc   = 1'b0;
      fail_wr   = 1'b0;
      fail_to   = 1'b0;
      case (state)
         IDLE, PASS, FAIL: begin
            if (start) begin
               state_nxt = RUN;
               arm       = 1'b1;
            end
         end
         RUN: begin
            if (len == '0) begin
               state_nxt = PASS;
            end else if (wr.mem_write && !ignored) begin
               // The ignore address takes priority over a table match.
               if (hit) begin
                  ptr_inc = 1'b1;
                  if (ptr == len - (IW+1)'(1)) state_nxt = PASS;
               end else if (STRICT) begin
                  state_nxt = FAIL;
                  fail_wr   = 1'b1;
               end
            end
            // Timeout only applies when nothing else decided this cycle,
            // so a final match on the expiry cycle still passes.
            if (state_nxt == RUN && at_limit) begin
               state_nxt = FAIL;
               fail_to   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            exp_addr[i] <= '0;
            exp_data[i] <= '0;
         end
         len         <= '0;
         ptr         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
         fail_idx    <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
         cycle_count <= '0;
      end else begin
         if (cfg_we && state != RUN) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (cfg_idx == IW'(i)) begin
                  exp_addr[i] <= cfg_addr;
                  exp_data[i] <= cfg_data;
               end
            end
         end

         busy <= state_nxt == RUN;
         done <= (state_nxt == PASS) || (state_nxt == FAIL);
         pass <= state_nxt == PASS;
         fail <= state_nxt == FAIL;

         if (arm) begin
            len         <= len_clamped;
            ptr         <= '0;
            cycle_count <= '0;
            timeout     <= 1'b0;
            fail_idx    <= '0;
            fail_addr   <= '0;
            fail_data   <= '0;
         end

         if (state == RUN) begin
            if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
            if (ptr_inc) ptr <= ptr + (IW+1)'(1);
            if (fail_wr) begin
               fail_idx  <= ptr[IW-1:0];
               fail_addr <= wr.data_adr;
               fail_data <= wr.write_data;
            end
            if (fail_to) begin
               timeout   <= 1'b1;
               fail_idx  <= ptr[IW-1:0];
               fail_addr <= '0;
               fail_data <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;
   localparam int IW = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [31:0] cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic [2:0]  cfg_len = '0;
   logic        start = 1'b0;

   logic        s_busy, s_done, s_pass, s_fail, s_timeout;
   logic [1:0]  s_fail_idx;
   logic [31:0] s_fail_addr, s_fail_data, s_cycle;
   logic        l_busy, l_done, l_pass, l_fail, l_timeout;
   logic [1:0]  l_fail_idx;
   logic [31:0] l_fail_addr, l_fail_data, l_cycle;

   int total = 0;
   int bad   = 0;

   mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) wr_if ();

   always #5 clk = ~clk;

   // Strict checker: unexpected writes fail.
   mem_write_checker #(.DEPTH(4), .TIMEOUT(16), .STRICT(1'b1)) dut_s (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
      .start(start), .wr(wr_if),
      .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail),
      .timeout(s_timeout), .fail_idx(s_fail_idx), .fail_addr(s_fail_addr),
      .fail_data(s_fail_data), .cycle_count(s_cycle));

   // Lenient checker on the same stimulus: unexpected writes are ignored.
   mem_write_checker #(.DEPTH(4), .TIMEOUT(16), .STRICT(1'b0)) dut_l (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
      .start(start), .wr(wr_if),
      .busy(l_busy), .done(l_done), .pass(l_pass), .fail(l_fail),
      .timeout(l_timeout), .fail_idx(l_fail_idx), .fail_addr(l_fail_addr),
      .fail_data(l_fail_data), .cycle_count(l_cycle));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic start_run(input logic [2:0] n);
      cfg_len = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_if.mem_write = 1'b1; wr_if.data_adr = a; wr_if.write_data = d;
      tick();
      wr_if.mem_write = 1'b0;
   endtask

   initial begin
      wr_if.mem_write  = 1'b0;
      wr_if.data_adr   = '0;
      wr_if.write_data = '0;

      // Reset state
      #1;
      chk("rst_busy", s_busy, 0);
      chk("rst_done", s_done, 0);
      chk("rst_pass", s_pass, 0);
      chk("rst_fail", s_fail, 0);
      chk("rst_timeout", s_timeout, 0);
      chk("rst_fail_idx", s_fail_idx, 0);
      chk("rst_fail_addr", s_fail_addr, 0);
      chk("rst_fail_data", s_fail_data, 0);
      chk("rst_cycle", s_cycle, 0);
      #2 reset = 1'b0;

      // Ignored address then matching write passes
      cfg(2'd0, 32'd100, 32'd3);
      start_run(3'd1);
      chk("arm_busy", s_busy, 1);
      chk("arm_cycle", s_cycle, 0);
      wr(32'd96, 32'd5);
      chk("ign_busy", s_busy, 1);
      chk("ign_pass", s_pass, 0);
      wr(32'd100, 32'd3);
      chk("p1_pass", s_pass, 1);
      chk("p1_fail", s_fail, 0);
      chk("p1_done", s_done, 1);
      chk("p1_busy", s_busy, 0);
      chk("p1_cycle", s_cycle, 2);
      chk("p1_l_pass", l_pass, 1);
      wr(32'd104, 32'd7);
      chk("p1_sticky", s_pass, 1);
      chk("p1_sticky_fail", s_fail, 0);
      chk("p1_sticky_cycle", s_cycle, 2);

      // Strict fails on unexpected write; lenient keeps running until timeout
      start_run(3'd1);
      wr(32'd104, 32'd7);
      chk("f1_fail", s_fail, 1);
      chk("f1_pass", s_pass, 0);
      chk("f1_idx", s_fail_idx, 0);
      chk("f1_addr", s_fail_addr, 104);
      chk("f1_data", s_fail_data, 7);
      chk("f1_timeout", s_timeout, 0);
      chk("f1_l_busy", l_busy, 1);
      idle(15);
      chk("f1_l_fail", l_fail, 1);
      chk("f1_l_timeout", l_timeout, 1);
      chk("f1_l_cycle", l_cycle, 16);
      chk("f1_s_sticky_addr", s_fail_addr, 104);

      // Two-entry table with stray and out-of-order writes
      cfg(2'd1, 32'd104, 32'd9);
      start_run(3'd2);
      wr(32'd108, 32'd1);
      chk("f2_fail", s_fail, 1);
      chk("f2_addr", s_fail_addr, 108);
      chk("f2_data", s_fail_data, 1);
      chk("l2_busy_a", l_busy, 1);
      wr(32'd104, 32'd9);
      chk("l2_ooo_busy", l_busy, 1);
      chk("l2_ooo_pass", l_pass, 0);
      wr(32'd100, 32'd3);
      chk("l2_busy_b", l_busy, 1);
      wr(32'd104, 32'd9);
      chk("l2_pass", l_pass, 1);
      chk("l2_cycle", l_cycle, 4);
      chk("f2_sticky_addr", s_fail_addr, 108);

      // Failure at second entry records pointer 1; lenient times out at pointer 1
      start_run(3'd2);
      wr(32'd100, 32'd3);
      wr(32'd108, 32'd1);
      chk("f3_fail", s_fail, 1);
      chk("f3_idx", s_fail_idx, 1);
      idle(14);
      chk("l3_fail", l_fail, 1);
      chk("l3_timeout", l_timeout, 1);
      chk("l3_idx", l_fail_idx, 1);
      chk("l3_addr", l_fail_addr, 0);
      chk("l3_cycle", l_cycle, 16);

      // Timeout with no writes
      start_run(3'd1);
      idle(15);
      chk("to_busy", s_busy, 1);
      chk("to_not_yet", s_fail, 0);
      chk("to_cycle15", s_cycle, 15);
      idle(1);
      chk("to_fail", s_fail, 1);
      chk("to_timeout", s_timeout, 1);
      chk("to_cycle", s_cycle, 16);
      chk("to_addr", s_fail_addr, 0);
      chk("to_idx", s_fail_idx, 0);
      chk("to_pass", s_pass, 0);

      // Final match on the expiry cycle wins
      start_run(3'd1);
      idle(15);
      wr(32'd100, 32'd3);
      chk("race_pass", s_pass, 1);
      chk("race_timeout", s_timeout, 0);
      chk("race_cycle", s_cycle, 16);

      // Zero length passes two cycles after start
      start_run(3'd0);
      chk("z_busy", s_busy, 1);
      tick();
      chk("z_pass", s_pass, 1);
      chk("z_cycle", s_cycle, 1);

      // Length clamps to DEPTH; table writes during RUN are ignored
      cfg(2'd2, 32'd200, 32'd20);
      cfg(2'd3, 32'd204, 32'd21);
      start_run(3'd7);
      cfg(2'd0, 32'd300, 32'd30);
      wr(32'd100, 32'd3);
      wr(32'd104, 32'd9);
      wr(32'd200, 32'd20);
      chk("cl_busy", s_busy, 1);
      wr(32'd204, 32'd21);
      chk("cl_pass", s_pass, 1);
      chk("cl_cycle", s_cycle, 5);

      // Reset mid-RUN aborts immediately and clears the table
      start_run(3'd1);
      idle(2);
      reset = 1'b1;
      #1;
      chk("mr_busy", s_busy, 0);
      chk("mr_done", s_done, 0);
      chk("mr_pass", s_pass, 0);
      chk("mr_cycle", s_cycle, 0);
      chk("mr_l_busy", l_busy, 0);
      #1 reset = 1'b0;
      start_run(3'd1);
      wr(32'd0, 32'd0);
      chk("mr_pass_after", s_pass, 1);
      chk("mr_fail_after", s_fail, 0);
      chk("mr_l_pass_after", l_pass, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter ADDR_W, default 32, sets the write-address width.
REQ-002 Parameter DATA_W, default 32, sets the write-data width.
REQ-003 Parameter DEPTH, default 4, sets the number of expected-write table entries; legal range is 1..16.
REQ-004 Parameter IGNORE_ADDR, default 96, names a write address that is always ignored.
REQ-005 Parameter TIMEOUT, default 1024, gives the maximum number of RUN cycles before a timeout failure.
REQ-006 Parameter STRICT, default 1: 1 means any unexpected write fails; 0 means unexpected writes are ignored.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-008 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-009 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 Port cfg_we, input, 1 bit: writes one table entry.
REQ-011 Port cfg_idx, input, IW = max(1,$clog2(DEPTH)) bits: index of the table entry to write.
REQ-012 Port cfg_addr, input, ADDR_W bits: expected address for the entry.
REQ-013 Port cfg_data, input, DATA_W bits: expected data for the entry.
REQ-014 Port cfg_len, input, IW+1 bits: number of valid entries, sampled on start.
REQ-015 Port start, input, 1 bit: arms the checker.
REQ-016 Port mem_write, input, 1 bit: monitored write strobe.
REQ-017 Port data_adr, input, ADDR_W bits: monitored write address.
REQ-018 Port write_data, input, DATA_W bits: monitored write data.
REQ-019 Port busy, output, 1 bit: high while in RUN.
REQ-020 Port done, output, 1 bit: high in PASS or FAIL.
REQ-021 Port pass, output, 1 bit: high in PASS.
REQ-022 Port fail, output, 1 bit: high in FAIL.
REQ-023 Port timeout, output, 1 bit: high when FAIL was caused by timeout.
REQ-024 Port fail_idx, output, IW bits: table pointer at the time of failure.
REQ-025 Port fail_addr, output, ADDR_W bits: address of the offending write.
REQ-026 Port fail_data, output, DATA_W bits: data of the offending write.
REQ-027 Port cycle_count, output, 32 bits: RUN cycles elapsed, saturating at 2^32-1.

Function
REQ-028 The FSM SHALL have states IDLE, RUN, PASS and FAIL.
REQ-029 cfg_we SHALL write exp_addr[cfg_idx] and exp_data[cfg_idx] in IDLE, PASS or FAIL, be ignored in RUN, and ignore any cfg_idx >= DEPTH.
REQ-030 start in IDLE, PASS or FAIL SHALL latch len = min(cfg_len, DEPTH), clear ptr, cycle_count, timeout and the fail_* outputs, and enter RUN on the next cycle; start in RUN SHALL be ignored.
REQ-031 If the latched len is 0, the FSM SHALL enter PASS one cycle after entering RUN, without inspecting any write.
REQ-032 In RUN with mem_write=1 and data_adr==IGNORE_ADDR, the write SHALL be ignored.
REQ-033 In RUN with mem_write=1, data_adr==exp_addr[ptr] and write_data==exp_data[ptr], ptr SHALL increment; when ptr==len-1 the FSM SHALL enter PASS on the next edge.
REQ-034 Any other write in RUN SHALL, if STRICT=1, enter FAIL and capture fail_idx=ptr, fail_addr=data_adr and fail_data=write_data; if STRICT=0 it SHALL be ignored.
REQ-035 A write at IGNORE_ADDR that also matches the current entry SHALL be ignored, because the ignore rule has priority.
REQ-036 cycle_count SHALL increment on every RUN cycle.
REQ-037 If TIMEOUT RUN cycles elapse with no PASS/FAIL decision, the FSM SHALL enter FAIL with timeout=1, fail_idx=ptr and fail_addr/fail_data=0.
REQ-038 A matching final write on the same cycle as timeout expiry SHALL win and produce PASS.
REQ-039 PASS and FAIL SHALL be sticky until the next start or reset, and mem_write SHALL be ignored in both states.
REQ-040 All outputs SHALL be registered, with decision latency of 1 cycle from the qualifying write edge to pass/fail.

Reset
REQ-041 Reset SHALL force state IDLE, ptr=0, len=0, cycle_count=0, and busy, done, pass, fail, timeout, fail_idx, fail_addr and fail_data all to 0.
REQ-042 The table contents SHALL be cleared to 0 on reset.
REQ-043 Reset asserted mid-RUN SHALL abort the check immediately, with no pass/fail pulse.

Verification
REQ-044 Table {(100,3)}, len=1, start; writes (96,5) then (100,3) -> pass=1 one cycle after the second write; fail=0.
REQ-045 STRICT=1, same table; write (104,7) -> fail=1, fail_idx=0, fail_addr=104, fail_data=7, timeout=0.
REQ-046 STRICT=0, table {(100,3),(104,9)}, len=2; writes (108,1), (100,3), (104,9) -> pass=1; writes out of order -> still RUN.
REQ-047 TIMEOUT=16, len=1, no writes -> fail=1 and timeout=1 after 16 RUN cycles, cycle_count=16.
REQ-048 cfg_len=0 then start -> pass=1 two cycles after start; cfg_len=DEPTH+3 -> len clamps to DEPTH.
REQ-049 Reset pulse mid-RUN -> all outputs 0 and state IDLE immediately; a following start plus the matching write -> pass.
